// File: rtl/key_debounce_multi.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// key_debounce_multi
//
// Multi-channel push-button debouncer and event generator. Every active-low
// key gets a two-flop synchroniser, a private debounce/long-press counter and
// its own one-hot FSM. Per key the block reports a one-cycle press pulse, a
// one-cycle release pulse, a one-cycle long-press pulse and a debounced level.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous, active-low reset
//   key_n          raw asynchronous key inputs, 0 = pressed
//   press_pulse    one-cycle pulse per key when a press is accepted
//   release_pulse  one-cycle pulse per key when a release is accepted
//   long_pulse     one-cycle pulse per key when a press has been held LONG_CYC
//   key_level      debounced key state, 1 = pressed
//   any_press      OR of all press pulses, aligned with them
// ---------------------------------------------------------------------------
module key_debounce_multi #(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = 10,
  parameter int LONG_CYC     = 50,
  parameter int CNT_W        = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] key_level,
  output logic              any_press
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

  // One-hot channel states; any other pattern is treated as illegal.
  typedef enum logic [4:0] {
    IDLE       = 5'b00001,
    PRESS_DB   = 5'b00010,
    HELD       = 5'b00100,
    LONG_HELD  = 5'b01000,
    RELEASE_DB = 5'b10000
  } state_e;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] ks_q;
  logic [N_KEYS-1:0] press_d;
  logic [N_KEYS-1:0] release_d;
  logic [N_KEYS-1:0] long_d;
  logic [N_KEYS-1:0] level_d;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] release_q;
  logic [N_KEYS-1:0] long_q;
  logic [N_KEYS-1:0] level_q;
  logic              any_q;

  // Two-flop synchroniser; reset loads the released level so that a key
  // held through reset is seen as a fresh press afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '1;
      ks_q    <= '1;
    end else begin
      sync1_q <= key_n;
      ks_q    <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : gCh
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             longDone_q, longDone_d;
    logic             ks;
    logic             pressD, releaseD, longD, levelD;

    assign ks = ks_q[g];

    // Channel state register.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        longDone_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        longDone_q <= longDone_d;
      end
    end

    // Next-state logic. The counter saturates at each terminal value because
    // every terminal compare leaves the counting state. longDone remembers
    // that this press already produced its long pulse, so a release glitch
    // that drops back to HELD only re-enters LONG_HELD silently.
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      longDone_d = longDone_q;
      case (state_q)
        IDLE: begin
          cnt_d      = '0;
          longDone_d = 1'b0;
          if (!ks) state_d = PRESS_DB;
        end
        PRESS_DB: begin
          if (ks) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (ks) begin
            state_d = RELEASE_DB;
            cnt_d   = '0;
          end else if (cnt_q == LONG_LAST) begin
            state_d    = LONG_HELD;
            longDone_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LONG_HELD: begin
          if (ks) begin
            state_d = RELEASE_DB;
            cnt_d   = '0;
          end
        end
        RELEASE_DB: begin
          if (!ks) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          cnt_d      = '0;
          longDone_d = 1'b0;
        end
      endcase
    end

    // Output decode: next values of the registered pulses and level, taken
    // from the same transition conditions as the next-state logic.
    always_comb begin
      pressD   = 1'b0;
      releaseD = 1'b0;
      longD    = 1'b0;
      levelD   = 1'b0;
      case (state_q)
        PRESS_DB: begin
          pressD = !ks && (cnt_q == DB_LAST);
          levelD = pressD;
        end
        HELD: begin
          longD  = !ks && (cnt_q == LONG_LAST) && !longDone_q;
          levelD = 1'b1;
        end
        LONG_HELD: begin
          levelD = 1'b1;
        end
        RELEASE_DB: begin
          releaseD = ks && (cnt_q == DB_LAST);
          levelD   = !releaseD;
        end
        default: begin
          levelD = 1'b0;
        end
      endcase
    end

    assign press_d[g]   = pressD;
    assign release_d[g] = releaseD;
    assign long_d[g]    = longD;
    assign level_d[g]   = levelD;
  end

  // Output registers shared by all channels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      level_q   <= '0;
      any_q     <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      level_q   <= level_d;
      any_q     <= |press_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign key_level     = level_q;
  assign any_press     = any_q;

endmodule
